fft_pingpong_ram: RTL and testbench
===================================

Name: fft_pingpong_ram

Overview:
- Parametrised two-bank (ping-pong) on-chip sample RAM; successor to the fixed 2048x32 dual-port FFT buffer.
- Port A streams acquisition samples into the fill bank with an auto-incrementing address.
- Port B gives the FFT engine random, in-place read/write access to the other bank, with an optional bit-reversed addressing mode.
- Bank swap runs on a handshake and reports overruns; it sits between the sample front-end and the FFT core.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 11, address width; DEPTH = 2**ADDR_W words per bank.
- BE_W, DATA_W/8, byte-enable width (derived; not overridden).
- CNT_W, 16, width of drop_count.

Ports:
- clk_50mhz_clk  in  1  single clock; all logic is on the rising edge.
- reset_reset_n  in  1  asynchronous, active-low reset.
- a_valid  in  1  sample present on a_data.
- a_data  in  DATA_W  sample word.
- a_ready  out  1  fill bank can accept a sample.
- b_address  in  ADDR_W  FFT word address.
- b_chipselect  in  1  port B select.
- b_clken  in  1  port B clock enable.
- b_write  in  1  write strobe.
- b_writedata  in  DATA_W  write data.
- b_byteenable  in  BE_W  per-byte write enable.
- b_readdata  out  DATA_W  registered read data.
- b_bitrev  in  1  1 = physical address is bit-reversed b_address.
- b_done  in  1  single-cycle pulse: FFT has finished with its bank.
- frame_ready  out  1  single-cycle pulse: new full bank handed to port B.
- bank_sel  out  1  bank currently owned by port A; port B owns ~bank_sel.
- drop_count  out  CNT_W  saturating count of samples rejected while a_ready=0.

Behaviour:
- Reset (asynchronous, active-low) drives:
  - bank_sel=0, fill_cnt=0, a_full=0, b_busy=0.
  - frame_ready=0, drop_count=0, b_readdata=0.
  - a_ready=1 after reset release.
  - RAM contents are undefined.
- Reset asserted mid-operation: the partial frame is discarded, b_busy is cleared, and control state returns to the reset values above.
- a_ready = ~a_full (combinational from registered state).
- Accepted sample, i.e. a_valid & a_ready:
  - write a_data, all bytes, to bank[bank_sel][fill_cnt];
  - fill_cnt increments, wrapping DEPTH-1 -> 0;
  - the write at fill_cnt = DEPTH-1 sets a_full=1.
- Rejected sample, i.e. a_valid & ~a_ready: drop_count increments and saturates at 2**CNT_W-1; no RAM write occurs.
- Swap rule, evaluated on registered state each cycle. If a_full & ~b_busy, then at the next edge:
  - bank_sel toggles;
  - a_full=0, b_busy=1;
  - frame_ready=1 for exactly one cycle.
- b_done handling:
  - b_done & b_busy: b_busy=0 at the next edge.
  - b_done & ~b_busy: ignored.
  - b_done in the same cycle as a_full: b_busy clears at edge N and the swap happens at edge N+1. Minimum b_done-to-frame_ready latency is 2 cycles.
- Port B physical address:
  - b_bitrev ? {b_address[0..ADDR_W-1]} : b_address;
  - always into bank ~bank_sel.
- Port B access when b_chipselect & b_clken:
  - read: b_readdata updates 1 cycle later with the selected word;
  - write (additionally requires b_write & b_busy): only bytes with b_byteenable[i]=1 change; read-during-write on the same address returns old data.
- b_clken=0 or b_chipselect=0: no access, and b_readdata holds its value.
- b_write while ~b_busy is ignored, so the bank being filled or idle is protected.
- Port A and port B never address the same bank, so there are no cross-port collisions.
- frame_ready and b_done are not queued: at most one filled bank waits. While a_full & b_busy, a_ready=0 and samples are dropped and counted.

Test Plan:
- Reset: hold reset_reset_n=0 mid-fill -> a_ready=1, bank_sel=0, b_readdata=0, drop_count=0, frame_ready=0.
- Fill: ADDR_W=4, stream 16 samples 0x100..0x10F with a_valid always high:
  - frame_ready pulses 1 cycle, 1 cycle after the 16th accept;
  - bank_sel=1;
  - port B reads of addr 0..15 return 0x100..0x10F with 1-cycle latency.
- Bit-reverse: same frame with b_bitrev=1, b_address=1 -> 0x108; b_address=3 -> 0x10C.
- Byte write: b_busy=1, write 0xAABBCCDD with b_byteenable=4'b0101 to addr 2 (old 0x102) -> read returns 0x00BB01DD.
- Backpressure: fill second bank without b_done -> a_ready=0. Offer 5 more samples -> drop_count=5, no RAM change. Pulse b_done -> frame_ready 2 cycles later, bank_sel=0, a_ready=1.
- Guard cases:
  - b_write with b_busy=0 leaves the word unchanged;
  - b_done with b_busy=0 has no effect;
  - b_clken=0 holds b_readdata across an address change.

Source files
------------

// File: rtl/fft_pingpong_ram.sv
// Two-bank ping-pong sample RAM: port A streams samples into the fill bank while
// port B gives the FFT engine in-place, optionally bit-reversed, access to the other bank.
module fft_pingpong_ram #(
    parameter int unsigned   DATA_W = 32,
    parameter int unsigned   ADDR_W = 11,
    parameter int unsigned   CNT_W  = 16,
    localparam int unsigned  BE_W   = DATA_W / 8
) (
    input  logic              clk_50mhz_clk,
    input  logic              reset_reset_n,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] b_address,
    input  logic              b_chipselect,
    input  logic              b_clken,
    input  logic              b_write,
    input  logic [DATA_W-1:0] b_writedata,
    input  logic [BE_W-1:0]   b_byteenable,
    output logic [DATA_W-1:0] b_readdata,
    input  logic              b_bitrev,
    input  logic              b_done,
    output logic              frame_ready,
    output logic              bank_sel,
    output logic [CNT_W-1:0]  drop_count
);

    localparam int unsigned MEM_WORDS = 2 ** (ADDR_W + 1);

    logic [DATA_W-1:0] mem [MEM_WORDS];

    logic [ADDR_W-1:0] fill_cnt;
    logic              a_full;
    logic              b_busy;

    logic              a_accept;
    logic              a_reject;
    logic              swap;
    logic              b_access;
    logic              b_wr;
    logic [ADDR_W-1:0] b_rev;
    logic [ADDR_W-1:0] b_phys;

    assign a_ready  = ~a_full;
    assign a_accept = a_valid & ~a_full;
    assign a_reject = a_valid & a_full;
    assign swap     = a_full & ~b_busy;
    assign b_access = b_chipselect & b_clken;
    assign b_wr     = b_access & b_write & b_busy;
    assign b_phys   = b_bitrev ? b_rev : b_address;

    // Mirror the FFT word address for bit-reversed access.
    always_comb begin
        b_rev = '0;
        for (int i = 0; i < int'(ADDR_W); i++) begin
            b_rev[i] = b_address[int'(ADDR_W) - 1 - i];
        end
    end

    // Bank storage; the two ports always target different banks.
    always_ff @(posedge clk_50mhz_clk) begin
        if (a_accept) begin
            mem[{bank_sel, fill_cnt}] <= a_data;
        end
        if (b_wr) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (b_byteenable[i]) begin
                    mem[{~bank_sel, b_phys}][i*8 +: 8] <= b_writedata[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_50mhz_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            b_readdata <= '0;
        end else if (b_access) begin
            b_readdata <= mem[{~bank_sel, b_phys}];
        end
    end

    // Fill pointer, bank handshake and overrun accounting.
    always_ff @(posedge clk_50mhz_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            bank_sel    <= 1'b0;
            fill_cnt    <= '0;
            a_full      <= 1'b0;
            b_busy      <= 1'b0;
            frame_ready <= 1'b0;
            drop_count  <= '0;
        end else begin
            frame_ready <= 1'b0;
            if (a_accept) begin
                fill_cnt <= fill_cnt + ADDR_W'(1);
                if (&fill_cnt) begin
                    a_full <= 1'b1;
                end
            end
            if (a_reject && !(&drop_count)) begin
                drop_count <= drop_count + CNT_W'(1);
            end
            if (swap) begin
                bank_sel    <= ~bank_sel;
                a_full      <= 1'b0;
                b_busy      <= 1'b1;
                frame_ready <= 1'b1;
            end else if (b_done && b_busy) begin
                b_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_pingpong_ram.sv
// Randomised scoreboard bench for fft_pingpong_ram with a bank-level reference model.
module tb_fft_pingpong_ram;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int CW    = 3;
    localparam int DMAX  = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_valid = 1'b0;
    logic [31:0]   a_data = '0;
    logic          a_ready;
    logic [AW-1:0] b_address = '0;
    logic          b_chipselect = 1'b0;
    logic          b_clken = 1'b0;
    logic          b_write = 1'b0;
    logic [31:0]   b_writedata = '0;
    logic [3:0]    b_byteenable = '0;
    logic [31:0]   b_readdata;
    logic          b_bitrev = 1'b0;
    logic          b_done = 1'b0;
    logic          frame_ready;
    logic          bank_sel;
    logic [CW-1:0] drop_count;

    fft_pingpong_ram #(.DATA_W(32), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk_50mhz_clk (clk),
        .reset_reset_n (rst_n),
        .a_valid       (a_valid),
        .a_data        (a_data),
        .a_ready       (a_ready),
        .b_address     (b_address),
        .b_chipselect  (b_chipselect),
        .b_clken       (b_clken),
        .b_write       (b_write),
        .b_writedata   (b_writedata),
        .b_byteenable  (b_byteenable),
        .b_readdata    (b_readdata),
        .b_bitrev      (b_bitrev),
        .b_done        (b_done),
        .frame_ready   (frame_ready),
        .bank_sel      (bank_sel),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    // Reference model: contents of both banks, the bank port A fills, and FFT ownership.
    logic [31:0] mm [2][DEPTH];
    int          m_bank = 0;
    bit          m_busy = 1'b0;
    int          m_drops = 0;
    int          n_frames_exp = 0;
    int          n_frames_seen = 0;
    logic [31:0] last_rd = '0;
    logic [31:0] exp_q [$];

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic int brev(input int a);
        int r = 0;
        for (int k = 0; k < AW; k++) r = r * 2 + ((a >> k) & 1);
        return r;
    endfunction

    // Scoreboard monitor: every port B access yields one registered read word.
    always @(posedge clk) begin
        if (rst_n && b_chipselect && b_clken) begin
            #1;
            if (exp_q.size() == 0) begin
                chk("b_readdata_unexpected", b_readdata, 32'hxxxx_xxxx);
            end else begin
                chk("b_readdata", b_readdata, exp_q.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst_n && frame_ready) n_frames_seen++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic b_idle();
        @(negedge clk);
        b_chipselect = 1'b0;
        b_clken      = 1'b0;
        b_write      = 1'b0;
        b_bitrev     = 1'b0;
        b_byteenable = '0;
    endtask

    task automatic b_read(input int addr, input bit rev);
        int p;
        @(negedge clk);
        b_chipselect = 1'b1;
        b_clken      = 1'b1;
        b_write      = 1'b0;
        b_address    = AW'(addr);
        b_bitrev     = rev;
        p = rev ? brev(addr) : addr;
        last_rd = mm[1-m_bank][p];
        exp_q.push_back(last_rd);
    endtask

    task automatic b_wr(input int addr, input logic [31:0] data, input logic [3:0] be);
        @(negedge clk);
        b_chipselect = 1'b1;
        b_clken      = 1'b1;
        b_write      = 1'b1;
        b_bitrev     = 1'b0;
        b_address    = AW'(addr);
        b_writedata  = data;
        b_byteenable = be;
        last_rd = mm[1-m_bank][addr];
        exp_q.push_back(last_rd);
        if (m_busy) begin
            for (int k = 0; k < 4; k++)
                if (be[k]) mm[1-m_bank][addr][k*8 +: 8] = data[k*8 +: 8];
        end
    endtask

    task automatic fill(input bit fixed);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            a_valid = 1'b1;
            a_data  = fixed ? 32'h100 + 32'(i) : $urandom;
            mm[m_bank][i] = a_data;
        end
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic offer_drops(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            a_valid = 1'b1;
            a_data  = $urandom;
        end
        @(negedge clk);
        a_valid = 1'b0;
        m_drops = (m_drops + n > DMAX) ? DMAX : m_drops + n;
    endtask

    task automatic pulse_done();
        @(negedge clk);
        b_done = 1'b1;
        @(negedge clk);
        b_done = 1'b0;
        m_busy = 1'b0;
    endtask

    // Called one cycle after the final accept when port B is free.
    task automatic expect_swap(input string tag);
        chk({tag, "_a_ready_full"}, 32'(a_ready), 32'd0);
        chk({tag, "_frame_ready_early"}, 32'(frame_ready), 32'd0);
        @(negedge clk);
        chk({tag, "_frame_ready"}, 32'(frame_ready), 32'd1);
        chk({tag, "_bank_sel"}, 32'(bank_sel), 32'(1 - m_bank));
        chk({tag, "_a_ready"}, 32'(a_ready), 32'd1);
        m_bank = 1 - m_bank;
        m_busy = 1'b1;
        n_frames_exp++;
        @(negedge clk);
        chk({tag, "_frame_ready_pulse"}, 32'(frame_ready), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_a_ready", 32'(a_ready), 32'd1);

        // Partial frame, then reset mid-fill.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_valid = 1'b1;
            a_data  = $urandom;
        end
        @(negedge clk);
        a_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("rst_mid_a_ready", 32'(a_ready), 32'd1);
        chk("rst_mid_bank_sel", 32'(bank_sel), 32'd0);
        chk("rst_mid_b_readdata", b_readdata, 32'd0);
        chk("rst_mid_drop_count", 32'(drop_count), 32'd0);
        chk("rst_mid_frame_ready", 32'(frame_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        fill(1'b1);
        expect_swap("fill1");

        for (int i = 0; i < DEPTH; i++) b_read(i, 1'b0);
        b_read(1, 1'b1);
        b_read(3, 1'b1);
        b_idle();
        chk("bitrev_3", b_readdata, 32'h10C);

        b_wr(2, 32'hAABBCCDD, 4'b0101);
        b_read(2, 1'b0);
        b_idle();
        chk("byte_write", b_readdata, 32'h00BB01DD);

        // Clock enable low holds the read data across address changes.
        b_read(5, 1'b0);
        @(negedge clk);
        b_clken   = 1'b0;
        b_address = AW'(7);
        @(negedge clk);
        b_address = AW'(9);
        @(negedge clk);
        chk("clken_hold", b_readdata, last_rd);
        b_idle();

        // Second bank fills while the FFT still owns the first: backpressure.
        fill(1'b0);
        chk("bp_a_ready", 32'(a_ready), 32'd0);
        @(negedge clk);
        chk("bp_no_frame", 32'(frame_ready), 32'd0);
        chk("bp_bank_sel", 32'(bank_sel), 32'd1);
        offer_drops(5);
        chk("bp_drop5", 32'(drop_count), 32'(m_drops));
        offer_drops(5);
        chk("bp_drop_sat", 32'(drop_count), 32'(m_drops));

        pulse_done();
        chk("done_frame_wait", 32'(frame_ready), 32'd0);
        chk("done_bank_wait", 32'(bank_sel), 32'd1);
        chk("done_a_ready_wait", 32'(a_ready), 32'd0);
        @(negedge clk);
        chk("done_frame_ready", 32'(frame_ready), 32'd1);
        chk("done_bank_sel", 32'(bank_sel), 32'd0);
        chk("done_a_ready", 32'(a_ready), 32'd1);
        m_bank = 0;
        m_busy = 1'b1;
        n_frames_exp++;

        for (int i = 0; i < DEPTH; i++) b_read(i, 1'b0);
        b_idle();

        // Guards with port B released.
        pulse_done();
        b_wr(4, $urandom, 4'hF);
        b_read(4, 1'b0);
        b_idle();
        pulse_done();
        @(negedge clk);
        chk("idle_done_frame", 32'(frame_ready), 32'd0);
        chk("idle_done_bank", 32'(bank_sel), 32'd0);
        chk("idle_done_a_ready", 32'(a_ready), 32'd1);
        chk("idle_drop_hold", 32'(drop_count), 32'(m_drops));

        fill(1'b0);
        expect_swap("fill3");
        for (int i = 0; i < 8; i++) b_read(int'($urandom_range(0, DEPTH - 1)), 1'($urandom));
        b_idle();

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("frame_count", 32'(n_frames_seen), 32'(n_frames_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
